// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s_ha0;
  logic c_ha0;
  logic c_ha1;

  assign s_ha0 = a ^ b;
  assign c_ha0 = a & b;
  assign s     = s_ha0 ^ cin;
  assign c_ha1 = s_ha0 & cin;
  assign cout  = c_ha0 | c_ha1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, one bit per clock LSB first through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_nxt;
  logic             last_bit;

  serial_fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_nxt)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= {s_bit, sr[WIDTH-1:1]};
          carry <= c_nxt;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum   <= {s_bit, sr[WIDTH-1:1]};
            cout  <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge.
            ovf   <= carry ^ c_nxt;
`endif
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and observes 12 cycles after the start edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf,
                       output int busy_cnt, output int done_cnt, output int done_idx);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1;
    r_sum = 'x; r_cout = 1'bx; r_ovf = 1'bx;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
        r_sum = sum; r_cout = cout;
`ifdef SERIAL_ADDER_OVF_EN
        r_ovf = ovf;
`else
        r_ovf = 1'b0;
`endif
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    step(); step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum got %h want 00", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %0b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b want 0", ovf); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    logic [W-1:0] s; logic c, o; int bc, dc, di;
    do_op(8'h5A, 8'h3C, 1'b0, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h96) begin fails++; $display("FAIL add_sum got %h want 96", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL add_cout got %0b want 0", c); end
    tests++; if (bc != 8) begin fails++; $display("FAIL add_busy_cycles got %0d want 8", bc); end
    tests++; if (di != 8) begin fails++; $display("FAIL add_done_latency got %0d want 8", di); end
    tests++; if (dc != 1) begin fails++; $display("FAIL add_done_count got %0d want 1", dc); end
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] s; logic c, o; int bc, dc, di; int bad;
    do_op(8'hFF, 8'h01, 1'b0, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h00) begin fails++; $display("FAIL wrap_sum got %h want 00", s); end
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL wrap_cout got %0b want 1", c); end
    tests++; if (dc != 1) begin fails++; $display("FAIL wrap_done_pulse got %0d want 1", dc); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sum !== 8'h00 || cout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wrap_hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_sub();
    logic [W-1:0] s; logic c, o; int bc, dc, di;
    do_op(8'h10, 8'h20, 1'b1, s, c, o, bc, dc, di);
    tests++; if (s !== 8'hF0) begin fails++; $display("FAIL sub_lt_sum got %h want F0", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL sub_lt_cout got %0b want 0", c); end
    do_op(8'h20, 8'h10, 1'b1, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h10) begin fails++; $display("FAIL sub_ge_sum got %h want 10", s); end
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL sub_ge_cout got %0b want 1", c); end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] s; logic c; int dc, bc;
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0; dc = 0; bc = 0; s = 'x; c = 1'bx;
    for (int i = 0; i < 22; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'hF0; b = 8'h0F; sub = 1'b1; end
      if (i == 4) start = 1'b0;
      if (i == 8) start = 1'b1;
      if (i == 9) start = 1'b0;
      if (done) begin dc++; s = sum; c = cout; end
      if (busy && i >= 9) bc++;
      step();
    end
    tests++; if (s !== 8'h33) begin fails++; $display("FAIL ign_sum got %h want 33", s); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL ign_cout got %0b want 0", c); end
    tests++; if (dc != 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", dc); end
    tests++; if (bc != 0) begin fails++; $display("FAIL ign_second_op got %0d busy cycles want 0", bc); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic c, o; int bc, dc, di, dseen;
    a = 8'hAA; b = 8'h11; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    tests++; if (sum !== 8'h00) begin fails++; $display("FAIL rstmid_sum got %h want 00", sum); end
    tests++; if (cout !== 1'b0) begin fails++; $display("FAIL rstmid_cout got %0b want 0", cout); end
    step(); step();
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dseen++;
      step();
    end
    tests++; if (dseen != 0) begin fails++; $display("FAIL rstmid_no_done got %0d active cycles want 0", dseen); end
    do_op(8'h01, 8'h02, 1'b0, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h03) begin fails++; $display("FAIL rstmid_next_sum got %h want 03", s); end
  endtask

  task automatic test_start_held();
    int d0, d1;
    a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
    step();
    d0 = -1; d1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        if (d0 < 0) d0 = i;
        else if (d1 < 0) d1 = i;
      end
      if (i == 19) start = 1'b0;
      step();
    end
    tests++; if (d0 != 8) begin fails++; $display("FAIL held_first_done got %0d want 8", d0); end
    tests++; if (d1 != 18) begin fails++; $display("FAIL held_second_done got %0d want 18", d1); end
    tests++; if (sum !== 8'h07) begin fails++; $display("FAIL held_sum got %h want 07", sum); end
    for (int i = 0; i < 12; i++) step();
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] s; logic c, o; int bc, dc, di;
    do_op(8'h7F, 8'h01, 1'b0, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h80) begin fails++; $display("FAIL ovf_add_sum got %h want 80", s); end
    tests++; if (o !== 1'b1) begin fails++; $display("FAIL ovf_add_ovf got %0b want 1", o); end
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL ovf_add_cout got %0b want 0", c); end
    do_op(8'h80, 8'h01, 1'b1, s, c, o, bc, dc, di);
    tests++; if (s !== 8'h7F) begin fails++; $display("FAIL ovf_sub_sum got %h want 7F", s); end
    tests++; if (o !== 1'b1) begin fails++; $display("FAIL ovf_sub_ovf got %0b want 1", o); end
    do_op(8'h05, 8'h03, 1'b0, s, c, o, bc, dc, di);
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL ovf_none got %0b want 0", o); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_ignored_start();
    test_reset_mid();
    test_start_held();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
